// File: rtl/e203_exu_regfile_mp_pkg.sv
// Shared widths and helpers for the multi-port EXU register file.
// Holds the RV32E/RV32I register-count select, XLEN, index widths and the
// last-enabled-port-wins write selector used by every register slot.
package e203_exu_regfile_mp_pkg;

    localparam bit RFREG_NUM_IS_32 = 1'b1;

    localparam int E203_XLEN      = 32;
    localparam int E203_RFREG_NUM = RFREG_NUM_IS_32 ? 32 : 16;
    localparam int E203_RFIDX_W   = RFREG_NUM_IS_32 ? 5 : 4;

    // Upper bound on write ports; hit vectors are padded to this width.
    localparam int MAX_NWR = 3;

    typedef struct packed {
        logic       hit;
        logic [1:0] port;
    } wr_sel_t;

    // Highest-numbered hitting port wins a same-index write conflict.
    function automatic wr_sel_t prio_wr_sel(input logic [MAX_NWR-1:0] hit);
        wr_sel_t s;
        s.hit  = 1'b0;
        s.port = 2'd0;
        for (int p = 0; p < MAX_NWR; p++) begin
            if (hit[p]) begin
                s.hit  = 1'b1;
                s.port = 2'(p);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/e203_exu_rf_sb.sv
// Busy scoreboard for the EXU register file (outstanding long-pipe writes).
// Ports: clk/rst, sb_set/sb_set_idx (mark busy), clr_vld/clr_idx (retire),
// rd_idx -> rd_busy lookup, busy_vec full state (bit 0 always 0).
module e203_exu_rf_sb
    import e203_exu_regfile_mp_pkg::*;
#(
    parameter int RFREG_NUM = 32,
    parameter int RFIDX_W   = 5,
    parameter int NRD       = 2,
    parameter int NWR       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sb_set,
    input  logic [RFIDX_W-1:0]     sb_set_idx,
    input  logic [NWR-1:0]         clr_vld,
    input  logic [NWR*RFIDX_W-1:0] clr_idx,
    input  logic [NRD*RFIDX_W-1:0] rd_idx,
    output logic [NRD-1:0]         rd_busy,
    output logic [RFREG_NUM-1:0]   busy_vec
);

    logic [RFREG_NUM-1:0] busy_q;
    logic [RFREG_NUM-1:0] busy_d;

    // Clears are applied first so a same-cycle set (new owner) wins.
    // Indices outside 1..RFREG_NUM-1 match no slot and are dropped.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < RFREG_NUM; i++) begin
            for (int p = 0; p < NWR; p++) begin
                if (clr_vld[p] &&
                    clr_idx[p*RFIDX_W +: RFIDX_W] == RFIDX_W'(i)) begin
                    busy_d[i] = 1'b0;
                end
            end
            if (sb_set && sb_set_idx == RFIDX_W'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Registered state only: a clear in this cycle is not forwarded.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            for (int i = 0; i < RFREG_NUM; i++) begin
                if (rd_idx[k*RFIDX_W +: RFIDX_W] == RFIDX_W'(i)) begin
                    rd_busy[k] = busy_q[i];
                end
            end
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/e203_exu_regfile_mp.sv
// Multi-port EXU general-purpose register file with busy scoreboard.
// Ports: NRD combinational reads (rd_idx->rd_dat/rd_busy), NWR writes with
// highest-port priority, optional write bypass, sb_set/sb_clr, busy_vec, x1_r.
module e203_exu_regfile_mp
    import e203_exu_regfile_mp_pkg::*;
#(
    parameter int XLEN      = E203_XLEN,
    parameter int RFREG_NUM = E203_RFREG_NUM,
    parameter int RFIDX_W   = $clog2(RFREG_NUM),
    parameter int NRD       = 2,
    parameter int NWR       = 2,
    parameter int BYPASS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRD*RFIDX_W-1:0] rd_idx,
    output logic [NRD*XLEN-1:0]    rd_dat,
    output logic [NRD-1:0]         rd_busy,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR*RFIDX_W-1:0] wr_idx,
    input  logic [NWR*XLEN-1:0]    wr_dat,
    input  logic                   sb_set,
    input  logic [RFIDX_W-1:0]     sb_set_idx,
    input  logic [NWR-1:0]         sb_clr,
    output logic [RFREG_NUM-1:0]   busy_vec,
    output logic [XLEN-1:0]        x1_r
);

    logic [RFREG_NUM-1:0][XLEN-1:0] rf_vec;

    assign rf_vec[0] = '0;

    for (genvar i = 1; i < RFREG_NUM; i++) begin : g_reg
        logic [MAX_NWR-1:0] hit;
        wr_sel_t            sel;
        logic [XLEN-1:0]    rf_d;
        logic [XLEN-1:0]    rf_q;

        always_comb begin
            hit = '0;
            for (int p = 0; p < NWR; p++) begin
                hit[p] = wr_en[p] &&
                         (wr_idx[p*RFIDX_W +: RFIDX_W] == RFIDX_W'(i));
            end
            sel  = prio_wr_sel(hit);
            rf_d = sel.hit ? wr_dat[int'(sel.port)*XLEN +: XLEN] : rf_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rf_q <= '0;
            end else begin
                rf_q <= rf_d;
            end
        end

        assign rf_vec[i] = rf_q;
    end

    logic [RFIDX_W-1:0] rd_i;
    logic               rd_ok;

    // rd_ok marks an in-range, non-zero index; only those may be bypassed.
    // Ascending port scan leaves the highest-numbered writer's data.
    always_comb begin
        rd_dat = '0;
        rd_i   = '0;
        rd_ok  = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            rd_i  = rd_idx[k*RFIDX_W +: RFIDX_W];
            rd_ok = 1'b0;
            for (int i = 1; i < RFREG_NUM; i++) begin
                if (rd_i == RFIDX_W'(i)) begin
                    rd_dat[k*XLEN +: XLEN] = rf_vec[i];
                    rd_ok = 1'b1;
                end
            end
            if (BYPASS != 0 && rd_ok) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en[p] && wr_idx[p*RFIDX_W +: RFIDX_W] == rd_i) begin
                        rd_dat[k*XLEN +: XLEN] = wr_dat[p*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    e203_exu_rf_sb #(
        .RFREG_NUM (RFREG_NUM),
        .RFIDX_W   (RFIDX_W),
        .NRD       (NRD),
        .NWR       (NWR)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .sb_set     (sb_set),
        .sb_set_idx (sb_set_idx),
        .clr_vld    (wr_en & sb_clr),
        .clr_idx    (wr_idx),
        .rd_idx     (rd_idx),
        .rd_busy    (rd_busy),
        .busy_vec   (busy_vec)
    );

    assign x1_r = rf_vec[1];

endmodule

// File: tb/tb_e203_exu_regfile_mp.sv
// Testbench for e203_exu_regfile_mp: two instances sharing one stimulus bus.
// Instance a: 32 regs, 2R/2W, no bypass. Instance b: 16 regs, 4R/3W, bypass.
module tb_e203_exu_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] rd_idx;
    logic [2:0]  wr_en;
    logic [14:0] wr_idx;
    logic [95:0] wr_dat;
    logic        sb_set;
    logic [4:0]  sb_set_idx;
    logic [2:0]  sb_clr;

    logic [63:0]  a_rd_dat;
    logic [1:0]   a_rd_busy;
    logic [31:0]  a_busy_vec;
    logic [31:0]  a_x1;
    logic [127:0] b_rd_dat;
    logic [3:0]   b_rd_busy;
    logic [15:0]  b_busy_vec;
    logic [31:0]  b_x1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    e203_exu_regfile_mp #(
        .XLEN(32), .RFREG_NUM(32), .RFIDX_W(5),
        .NRD(2), .NWR(2), .BYPASS(0)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (rd_idx[9:0]),
        .rd_dat     (a_rd_dat),
        .rd_busy    (a_rd_busy),
        .wr_en      (wr_en[1:0]),
        .wr_idx     (wr_idx[9:0]),
        .wr_dat     (wr_dat[63:0]),
        .sb_set     (sb_set),
        .sb_set_idx (sb_set_idx),
        .sb_clr     (sb_clr[1:0]),
        .busy_vec   (a_busy_vec),
        .x1_r       (a_x1)
    );

    e203_exu_regfile_mp #(
        .XLEN(32), .RFREG_NUM(16), .RFIDX_W(5),
        .NRD(4), .NWR(3), .BYPASS(1)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (rd_idx),
        .rd_dat     (b_rd_dat),
        .rd_busy    (b_rd_busy),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_dat     (wr_dat),
        .sb_set     (sb_set),
        .sb_set_idx (sb_set_idx),
        .sb_clr     (sb_clr),
        .busy_vec   (b_busy_vec),
        .x1_r       (b_x1)
    );

    // Reference model: plain arrays, one per instance.
    logic [31:0] mreg  [2][32];
    bit          mbusy [2][32];

    function automatic int nreg(int d); return (d == 1) ? 16 : 32; endfunction
    function automatic int nrd(int d);  return (d == 1) ? 4 : 2;   endfunction
    function automatic int nwr(int d);  return (d == 1) ? 3 : 2;   endfunction

    function automatic bit ok_idx(int d, int idx);
        return idx != 0 && idx < nreg(d);
    endfunction

    function automatic logic [31:0] exp_rd(int d, int idx);
        logic [31:0] v;
        if (!ok_idx(d, idx)) return 32'd0;
        v = mreg[d][idx];
        if (d == 1) begin
            for (int p = 0; p < nwr(d); p++)
                if (wr_en[p] && int'(wr_idx[p*5 +: 5]) == idx)
                    v = wr_dat[p*32 +: 32];
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_bvec(int d);
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < nreg(d); i++) v[i] = mbusy[d][i];
        return v;
    endfunction

    task automatic model_step();
        int idx;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    mreg[d][i]  = '0;
                    mbusy[d][i] = 1'b0;
                end
            end else begin
                for (int p = 0; p < nwr(d); p++) begin
                    idx = int'(wr_idx[p*5 +: 5]);
                    if (wr_en[p] && ok_idx(d, idx))
                        mreg[d][idx] = wr_dat[p*32 +: 32];
                end
                for (int p = 0; p < nwr(d); p++) begin
                    idx = int'(wr_idx[p*5 +: 5]);
                    if (wr_en[p] && sb_clr[p] && ok_idx(d, idx))
                        mbusy[d][idx] = 1'b0;
                end
                idx = int'(sb_set_idx);
                if (sb_set && ok_idx(d, idx)) mbusy[d][idx] = 1'b1;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic full_check(string tag);
        int idx;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < nrd(d); k++) begin
                idx = int'(rd_idx[k*5 +: 5]);
                chk($sformatf("%s_d%0d_rd%0d", tag, d, k),
                    d ? b_rd_dat[k*32 +: 32] : 32'(a_rd_dat[k*32 +: 32]),
                    exp_rd(d, idx));
                chk($sformatf("%s_d%0d_busy%0d", tag, d, k),
                    32'(d ? b_rd_busy[k] : a_rd_busy[k]),
                    32'(ok_idx(d, idx) ? mbusy[d][idx] : 1'b0));
            end
            chk($sformatf("%s_d%0d_bvec", tag, d),
                d ? 32'(b_busy_vec) : a_busy_vec, exp_bvec(d));
            chk($sformatf("%s_d%0d_x1", tag, d),
                d ? b_x1 : a_x1, mreg[d][1]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        logic        r;
        logic [2:0]  we;
        logic [4:0]  i0;
        logic [31:0] d0;
        logic [4:0]  i1;
        logic [31:0] d1;
        logic        ss;
        logic [4:0]  ssi;
        logic [2:0]  sc;
        logic [4:0]  ri;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        ba;
        logic        bb;
    } vec_t;

    function automatic vec_t mk(logic r, logic [2:0] we,
                                logic [4:0] i0, logic [31:0] d0,
                                logic [4:0] i1, logic [31:0] d1,
                                logic ss, logic [4:0] ssi, logic [2:0] sc,
                                logic [4:0] ri, logic [31:0] ea,
                                logic [31:0] eb, logic ba, logic bb);
        vec_t v;
        v.r = r; v.we = we; v.i0 = i0; v.d0 = d0; v.i1 = i1; v.d1 = d1;
        v.ss = ss; v.ssi = ssi; v.sc = sc; v.ri = ri;
        v.ea = ea; v.eb = eb; v.ba = ba; v.bb = bb;
        return v;
    endfunction

    vec_t tbl [15];

    initial begin
        // Expected read/busy are for read port 0, sampled before the edge.
        tbl[0]  = mk(0, 3'b001, 5,  32'hDEADBEEF, 0, 0, 0, 0, 0, 5,
                     32'h0, 32'hDEADBEEF, 0, 0);
        tbl[1]  = mk(0, 3'b000, 0,  0, 0, 0, 0, 0, 0, 5,
                     32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        tbl[2]  = mk(0, 3'b001, 0,  32'hFFFFFFFF, 0, 0, 1, 0, 0, 0,
                     32'h0, 32'h0, 0, 0);
        tbl[3]  = mk(0, 3'b000, 0,  0, 0, 0, 0, 0, 0, 0,
                     32'h0, 32'h0, 0, 0);
        tbl[4]  = mk(0, 3'b011, 7,  32'h11, 7, 32'h22, 0, 0, 0, 7,
                     32'h0, 32'h22, 0, 0);
        tbl[5]  = mk(0, 3'b000, 0,  0, 0, 0, 0, 0, 0, 7,
                     32'h22, 32'h22, 0, 0);
        tbl[6]  = mk(0, 3'b000, 0,  0, 0, 0, 1, 9, 0, 9,
                     32'h0, 32'h0, 0, 0);
        tbl[7]  = mk(0, 3'b001, 9,  32'hAA, 0, 0, 1, 9, 3'b001, 9,
                     32'h0, 32'hAA, 1, 1);
        tbl[8]  = mk(0, 3'b001, 9,  32'hBB, 0, 0, 0, 0, 3'b001, 9,
                     32'hAA, 32'hBB, 1, 1);
        tbl[9]  = mk(0, 3'b000, 0,  0, 0, 0, 0, 0, 0, 9,
                     32'hBB, 32'hBB, 0, 0);
        tbl[10] = mk(0, 3'b001, 3,  32'h1234, 0, 0, 1, 3, 0, 3,
                     32'h0, 32'h1234, 0, 0);
        tbl[11] = mk(1, 3'b001, 3,  32'h5678, 0, 0, 0, 0, 0, 3,
                     32'h1234, 32'h5678, 1, 1);
        tbl[12] = mk(0, 3'b000, 0,  0, 0, 0, 0, 0, 0, 3,
                     32'h0, 32'h0, 0, 0);
        tbl[13] = mk(0, 3'b001, 20, 32'h5, 0, 0, 0, 0, 0, 20,
                     32'h0, 32'h0, 0, 0);
        tbl[14] = mk(0, 3'b000, 0,  0, 0, 0, 0, 0, 0, 20,
                     32'h5, 32'h0, 0, 0);

        rst = 1'b1; rd_idx = '0; wr_en = '0; wr_idx = '0; wr_dat = '0;
        sb_set = 1'b0; sb_set_idx = '0; sb_clr = '0;
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            rd_idx = {15'd0, 5'(i)};
            #1;
            chk($sformatf("rst_a_rd_x%0d", i), a_rd_dat[31:0], 32'd0);
            chk($sformatf("rst_b_rd_x%0d", i), b_rd_dat[31:0], 32'd0);
        end
        chk("rst_a_bvec", a_busy_vec, 32'd0);
        chk("rst_b_bvec", 32'(b_busy_vec), 32'd0);
        full_check("rst");
        tick();

        for (int i = 0; i < 15; i++) begin
            rst        = tbl[i].r;
            wr_en      = tbl[i].we;
            wr_idx     = {5'd0, tbl[i].i1, tbl[i].i0};
            wr_dat     = {32'd0, tbl[i].d1, tbl[i].d0};
            sb_set     = tbl[i].ss;
            sb_set_idx = tbl[i].ssi;
            sb_clr     = tbl[i].sc;
            rd_idx     = {15'd0, tbl[i].ri};
            #1;
            chk($sformatf("row%0d_a_rd", i), a_rd_dat[31:0], tbl[i].ea);
            chk($sformatf("row%0d_b_rd", i), b_rd_dat[31:0], tbl[i].eb);
            chk($sformatf("row%0d_a_busy", i), 32'(a_rd_busy[0]),
                32'(tbl[i].ba));
            chk($sformatf("row%0d_b_busy", i), 32'(b_rd_busy[0]),
                32'(tbl[i].bb));
            full_check($sformatf("row%0d", i));
            tick();
        end

        // Directed: x0 never busy after a set aimed at it.
        rst = 1'b0; wr_en = '0; sb_set = 1'b0; sb_clr = '0;
        #1;
        chk("x0_bvec_a", 32'(a_busy_vec[0]), 32'd0);
        chk("x0_bvec_b", 32'(b_busy_vec[0]), 32'd0);

        for (int c = 0; c < 1500; c++) begin
            rst        = ($urandom_range(0, 63) == 0);
            wr_en      = 3'($urandom);
            wr_idx     = 15'($urandom);
            if ($urandom_range(0, 3) == 0) wr_idx[9:5] = wr_idx[4:0];
            wr_dat     = {$urandom, $urandom, $urandom};
            sb_set     = 1'($urandom);
            sb_set_idx = 5'($urandom);
            sb_clr     = 3'($urandom);
            rd_idx     = 20'($urandom);
            if ($urandom_range(0, 3) == 0) rd_idx[4:0] = wr_idx[4:0];
            #1;
            full_check($sformatf("rnd%0d", c));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/e203_exu_regfile_mp.md
# e203_exu_regfile_mp

Parametrised multi-port general-purpose register file for the EXU, the successor to the single-write-port regfile. It has N read ports and M write ports, optional write-to-read bypass, and synchronous reset of register contents. A per-register busy scoreboard tracks outstanding long-pipe writebacks. It sits between decode/dispatch (reads, busy-set) and the writeback arbiter (writes, busy-clear).

## Interface
Parameters:
- XLEN, 32, data width.
- RFREG_NUM, 32, number of registers; 16 or 32 (RV32E/RV32I).
- RFIDX_W, $clog2(RFREG_NUM), index width (derived).
- NRD, 2, read ports (1..4).
- NWR, 2, write ports (1..3); a higher port number has higher priority.
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads.

Ports:
- clk  in  1  the only clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_idx  in  NRD*RFIDX_W  read indices, port k at [k*RFIDX_W +: RFIDX_W].
- rd_dat  out  NRD*XLEN  read data.
- rd_busy  out  NRD  busy flag of the indexed register.
- wr_en  in  NWR  write enables.
- wr_idx  in  NWR*RFIDX_W  write indices.
- wr_dat  in  NWR*XLEN  write data.
- sb_set  in  1  mark register sb_set_idx busy (long-pipe instruction dispatched).
- sb_set_idx  in  RFIDX_W  index to mark busy.
- sb_clr  in  NWR  per write port: this write retires an outstanding busy entry.
- busy_vec  out  RFREG_NUM  full scoreboard, bit 0 always 0.
- x1_r  out  XLEN  register x1, for the IFU return-address predictor.

## Operation
- x0 always reads 0 and is never busy. Writes, sets and clears that target x0 are ignored.
- Write: on a clock edge where wr_en[p] is high and wr_idx[p]≠0, reg[wr_idx[p]] ← wr_dat[p].
- Same-index conflict: when several enabled ports write the same index, the highest-numbered port's data is stored.
- Read: rd_dat[k] = reg[rd_idx[k]] (combinational).
  - When BYPASS=1 and an enabled write targets rd_idx[k]≠0 in the same cycle, rd_dat[k] returns the winning write data instead.
  - When BYPASS=0, reads never see same-cycle writes.
- Scoreboard busy[i]:
  - Set by sb_set on index i.
  - Cleared by wr_en[p]&sb_clr[p] on index i.
  - Set and clear on the same index in the same cycle: set wins, so busy stays 1 (a new owner).
  - Clearing an index that is not busy has no effect.
- rd_busy[k] = busy[rd_idx[k]], registered state only; there is no bypass of a same-cycle clear.
- sb_clr[p] is only meaningful while wr_en[p] is high.
- Out-of-range indices (≥RFREG_NUM, when RFREG_NUM is not a power of two) read 0 and are not busy. Writes to them are dropped.

## Timing
- Read latency is 0 cycles (combinational from rd_idx and, with BYPASS=1, from the write inputs).
- Write-to-read latency: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- Busy set/clear is visible on rd_busy and busy_vec the cycle after the edge.
- Reset: while rst is high at an edge, all registers and all busy bits become 0. All write, set and clear inputs that cycle are ignored.
  - The cycle after reset: rd_dat=0, rd_busy=0, busy_vec=0, x1_r=0.
  - Reset arriving mid-operation, with writes pending or busy bits set, discards everything; there is no partial retention.
- Outputs during reset cycles are driven by the (reset) state, so they are 0 except where a bypass is active.

## Structure
- Shared defines/package holds:
  - the RFREG_NUM_IS_32 select;
  - the XLEN and RFIDX widths;
  - a priority-write helper function (last-enabled-port-wins mux).
- One sub-module, e203_exu_rf_sb: the busy scoreboard, covering set/clear priority and the busy_vec/rd_busy lookup.
- The data array and write muxing stay in the top module as a generate loop over registers 1..RFREG_NUM-1. Register 0 is a constant.

## Test plan
- Reset then read all indices: every rd_dat=0, busy_vec=0. Write x5←0xDEADBEEF, and with BYPASS=0 read x5 the next cycle → 0xDEADBEEF.
- Write x0←0xFFFFFFFF on port 0 and read x0 → 0. sb_set on x0 → busy_vec[0] stays 0.
- Same cycle: port0 writes x7←0x11, port1 writes x7←0x22. Next cycle x7 → 0x22. With BYPASS=1, a same-cycle read of x7 → 0x22.
- sb_set x9 → rd_busy=1 next cycle. Then a cycle with wr_en[0], wr_idx=9, sb_clr[0] plus sb_set x9 → busy stays 1. A later clear-only cycle → 0.
- Set x3 busy and write x3←0x1234, then assert rst for 1 cycle together with a write x3←0x5678 → x3 reads 0, busy[3]=0.
- NRD=4, NWR=3, RFREG_NUM=16: randomized writes and reads against a reference model. Index 16..31 reads return 0.
